// File: rtl/da_table_builder.sv
// Offset-binary DA table generator: K-tap delay line plus a Gray-code walk that
// fills a shadow bank one entry per cycle, then ping-pong swaps it into view.
module da_table_builder #(
    parameter int DW = 8,
    parameter int K  = 3
) (
    input  logic                              clk,
    input  logic                              r,
    input  logic signed [DW-1:0]              x_in,
    input  logic                              x_vld,
    output logic                              x_rdy,
    input  logic        [K-1:0]               rd_addr,
    output logic signed [DW+$clog2(K+1)-1:0]  rd_data,
    output logic                              tbl_vld,
    output logic                              swap,
    output logic                              busy,
    output logic        [1:0]                 dbg_state
);
    localparam int TW = DW + $clog2(K+1);
    localparam int N  = 1 << K;

    // Handshake: a sample transfers on a rising edge where x_vld && x_rdy;
    // x_rdy is high only in IDLE, so the taps never move during a build.
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_STEP, S_SWAP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic signed [DW-1:0]   r_tap   [K];
    logic signed [TW-1:0]   r_bank0 [N];
    logic signed [TW-1:0]   r_bank1 [N];
    logic                   r_act;
    logic signed [TW-1:0]   r_acc;
    logic        [K-1:0]    r_i;
    logic                   r_tbl_vld;
    logic                   r_swap;
    logic signed [TW-1:0]   r_rd;

    logic signed [TW-1:0]   w_neg_sum;
    logic        [K-1:0]    w_gray;
    logic signed [DW-1:0]   w_sel;
    logic                   w_dir;
    logic signed [TW-1:0]   w_twice;
    logic signed [TW-1:0]   w_acc_next;
    logic                   w_wr_en;
    logic        [K-1:0]    w_wr_addr;
    logic signed [TW-1:0]   w_wr_data;

    // All-minus seed and the single tap whose sign flips at Gray step i.
    always_comb begin
        w_neg_sum = '0;
        w_sel     = '0;
        w_dir     = 1'b0;
        w_gray    = r_i ^ (r_i >> 1);
        for (int k = 0; k < K; k++) begin
            w_neg_sum = w_neg_sum - {{(TW-DW){r_tap[k][DW-1]}}, r_tap[k]};
        end
        for (int k = K - 1; k >= 0; k--) begin
            if (r_i[k]) begin
                w_sel = r_tap[k];
                w_dir = w_gray[k];
            end
        end
        w_twice    = {{(TW-DW){w_sel[DW-1]}}, w_sel} <<< 1;
        w_acc_next = w_dir ? (r_acc + w_twice) : (r_acc - w_twice);
    end

    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        case (r_state)
            S_IDLE: if (x_vld) w_next = S_INIT;
            S_INIT: begin
                w_next    = S_STEP;
                w_wr_en   = 1'b1;
                w_wr_data = w_neg_sum;
            end
            S_STEP: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_gray;
                w_wr_data = w_acc_next;
                if (r_i == '1) w_next = S_SWAP;
            end
            S_SWAP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_i       <= '0;
            r_act     <= 1'b0;
            r_tbl_vld <= 1'b0;
            r_swap    <= 1'b0;
            r_rd      <= '0;
            for (int k = 0; k < K; k++) r_tap[k] <= '0;
        end else begin
            r_state <= w_next;
            r_swap  <= (r_state == S_SWAP);
            r_rd    <= r_act ? r_bank1[rd_addr] : r_bank0[rd_addr];
            case (r_state)
                S_IDLE: begin
                    if (x_vld) begin
                        r_tap[0] <= x_in;
                        for (int k = 1; k < K; k++) r_tap[k] <= r_tap[k-1];
                    end
                end
                S_INIT: begin
                    r_acc <= w_neg_sum;
                    r_i   <= K'(1);
                end
                S_STEP: begin
                    r_acc <= w_acc_next;
                    r_i   <= r_i + K'(1);
                end
                S_SWAP: begin
                    r_act     <= ~r_act;
                    r_tbl_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Only the bank not selected by r_act is ever written.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int a = 0; a < N; a++) begin
                r_bank0[a] <= '0;
                r_bank1[a] <= '0;
            end
        end else if (w_wr_en) begin
            if (r_act) r_bank0[w_wr_addr] <= w_wr_data;
            else       r_bank1[w_wr_addr] <= w_wr_data;
        end
    end

    assign x_rdy     = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rd_data   = r_rd;
    assign tbl_vld   = r_tbl_vld;
    assign swap      = r_swap;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_da_table_builder.sv
// Randomised and directed bench for da_table_builder against a cycle-level
// model that recomputes each published table from the tap values directly.
module tb_da_table_builder;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int TW = DW + $clog2(K+1);
    localparam int N  = 1 << K;

    logic                 clk = 1'b0;
    logic                 r = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic                 x_vld = 1'b0;
    logic                 x_rdy;
    logic        [K-1:0]  rd_addr = '0;
    logic signed [TW-1:0] rd_data;
    logic                 tbl_vld;
    logic                 swap;
    logic                 busy;
    logic        [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    da_table_builder #(.DW(DW), .K(K)) dut (
        .clk(clk), .r(r), .x_in(x_in), .x_vld(x_vld), .x_rdy(x_rdy),
        .rd_addr(rd_addr), .rd_data(rd_data), .tbl_vld(tbl_vld),
        .swap(swap), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a build occupies N+1 edges after the accept edge, then the table
    // defined by table[a] = sum(a[k] ? +tap[k] : -tap[k]) becomes readable.
    int m_tap [K];
    int m_tbl [N];
    int m_cnt = 0;
    int m_rd  = 0;
    bit m_swap = 1'b0;
    bit m_vld  = 1'b0;

    function automatic int entry(input int a);
        int s = 0;
        for (int k = 0; k < K; k++) s += ((a >> k) & 1) ? m_tap[k] : -m_tap[k];
        return s;
    endfunction

    always @(posedge clk or negedge r) begin
        if (!r) begin
            for (int k = 0; k < K; k++) m_tap[k] = 0;
            for (int a = 0; a < N; a++) m_tbl[a] = 0;
            m_cnt = 0; m_rd = 0; m_swap = 1'b0; m_vld = 1'b0;
        end else begin
            m_rd   = m_tbl[rd_addr];
            m_swap = 1'b0;
            if (m_cnt == 0) begin
                if (x_vld) begin
                    for (int k = K - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
                    m_tap[0] = int'(x_in);
                    m_cnt = N + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    for (int a = 0; a < N; a++) m_tbl[a] = entry(a);
                    m_swap = 1'b1;
                    m_vld  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("x_rdy",   int'(x_rdy),   int'(m_cnt == 0));
            check("busy",    int'(busy),    int'(m_cnt != 0));
            check("swap",    int'(swap),    int'(m_swap));
            check("tbl_vld", int'(tbl_vld), int'(m_vld));
            check("rd_data", int'(rd_data), m_rd);
        end
    end

    task automatic wait_ready(input string name);
        int g = 0;
        while (!x_rdy && g < 40) begin
            rd_addr = K'($urandom_range(0, N - 1));
            @(negedge clk); #1;
            g++;
        end
        check(name, int'(x_rdy), 1);
    endtask

    task automatic feed(input int v);
        @(negedge clk); #1;
        wait_ready("feed_ready");
        x_vld = 1'b1;
        x_in  = DW'(v);
        @(negedge clk); #1;
        x_vld = 1'b0;
        x_in  = DW'($urandom_range(0, 255));
        wait_ready("build_done");
    endtask

    task automatic read_check(input int a, input int exp, input string name);
        @(negedge clk); #1;
        rd_addr = K'(a);
        @(negedge clk);
        check(name, int'(rd_data), exp);
    endtask

    initial begin
        int exp_basic [N];
        int seq, last, cyc, g;
        exp_basic = '{-60, 0, -20, 40, -40, 20, 0, 60};

        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk); #1;
        r = 1'b1;
        check("rst_x_rdy", int'(x_rdy), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tbl_vld", int'(tbl_vld), 0);
        for (int a = 0; a < N; a++) read_check(a, 0, "rst_read");

        feed(10); feed(20); feed(30);
        for (int a = 0; a < N; a++) read_check(a, exp_basic[a], "basic_tbl");

        feed(-128); feed(-128); feed(-128);
        read_check(0, 384, "ext_neg_a0");
        read_check(7, -384, "ext_neg_a7");
        feed(127); feed(127); feed(127);
        read_check(7, 381, "ext_pos_a7");
        read_check(0, -381, "ext_pos_a0");

        // Back-pressure: x_vld held, next value only after each accept.
        seq = 1; last = -1; cyc = 0;
        repeat (45) begin
            @(negedge clk); #1;
            x_vld = 1'b1;
            x_in  = DW'(seq);
            if (x_rdy) begin
                if (last >= 0) check("accept_interval", cyc - last, N + 2);
                last = cyc;
                seq++;
            end
            cyc++;
        end
        @(negedge clk); #1;
        x_vld = 1'b0;
        wait_ready("bp_done");
        read_check(7, (seq-1) + (seq-2) + (seq-3), "bp_sum");
        read_check(1, (seq-1) - (seq-2) - (seq-3), "bp_a1");
        read_check(7, 12, "bp_a7_lit");

        // Ping-pong isolation with the read address pinned during a build.
        @(negedge clk); #1;
        rd_addr = K'(7);
        @(negedge clk); #1;
        check("pp_before", int'(rd_data), 12);
        x_vld = 1'b1; x_in = DW'(7);
        @(negedge clk); #1;
        x_vld = 1'b0;
        g = 0;
        while (!x_rdy && g < 40) begin
            check("pp_old", int'(rd_data), 12);
            @(negedge clk); #1;
            g++;
        end
        check("pp_done", int'(x_rdy), 1);
        check("pp_swap_pulse", int'(swap), 1);
        check("pp_swap_read", int'(rd_data), 12);
        @(negedge clk); #1;
        check("pp_new", int'(rd_data), 16);
        check("pp_swap_one", int'(swap), 0);

        // Reset during STEP i=4: four edges after INIT completes.
        @(negedge clk); #1;
        x_vld = 1'b1; x_in = DW'(55);
        @(negedge clk); #1;
        x_vld = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("mid_busy", int'(busy), 1);
        r = 1'b0;
        #1;
        check("mid_rst_rdy", int'(x_rdy), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_vld", int'(tbl_vld), 0);
        check("mid_rst_swap", int'(swap), 0);
        check("mid_rst_rd", int'(rd_data), 0);
        @(negedge clk); #1;
        r = 1'b1;
        for (int a = 0; a < N; a++) read_check(a, 0, "mid_rst_read");
        feed(3); feed(-5); feed(100);
        read_check(0, -98, "post_rst_a0");
        read_check(5, 108, "post_rst_a5");
        read_check(2, -108, "post_rst_a2");

        repeat (20) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk); #1;
                rd_addr = K'($urandom_range(0, N - 1));
            end
            feed($urandom_range(0, 255) - 128);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
